// File: rtl/term_pkg.sv
// Shared terminal definitions: ASCII control/digit codes and the decimal-entry FSM state type.
package term_pkg;

    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_BS   = 8'h08;
    localparam logic [7:0] ASCII_DEL  = 8'h7F;
    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_NINE = 8'h39;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        CONVERT = 2'd1,
        PRESENT = 2'd2
    } dec_state_e;

endpackage

// File: rtl/ascii_digit_classify.sv
// Combinational byte classifier: decimal digit, line terminator, or backspace/delete.
module ascii_digit_classify
    import term_pkg::*;
(
    input  logic [7:0] char_i,
    output logic [3:0] digit_o,
    output logic       is_digit_o,
    output logic       is_term_o,
    output logic       is_bksp_o
);

    always_comb begin
        is_digit_o = (char_i >= ASCII_ZERO) && (char_i <= ASCII_NINE);
        // Low nibble of '0'..'9' is the digit value; forced to zero otherwise.
        digit_o    = is_digit_o ? char_i[3:0] : 4'd0;
        is_term_o  = (char_i == ASCII_CR) || (char_i == ASCII_LF);
        is_bksp_o  = (char_i == ASCII_BS) || (char_i == ASCII_DEL);
    end

endmodule

// File: rtl/decimal_entry_ctrl.sv
// Buffers ASCII decimal digits and converts them to a saturating unsigned value on CR/LF.
// Optional feature: define DEC_ENTRY_BACKSPACE_EN to make BS/DEL pop the newest digit.
module decimal_entry_ctrl
    import term_pkg::*;
#(
    parameter  int WIDTH      = 16,
    parameter  int MAX_DIGITS = 5,
    localparam int CW         = $clog2(MAX_DIGITS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic [WIDTH-1:0] num_value,
    output logic             num_valid,
    input  logic             num_ready,
    output logic             num_overflow,
    output logic             err_pulse,
    output logic [CW-1:0]    digit_count
);

`ifdef DEC_ENTRY_BACKSPACE_EN
    localparam bit BKSP_EN = 1'b1;
`else
    localparam bit BKSP_EN = 1'b0;
`endif

    dec_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic             vld_q, vld_d;
    logic             err_q, err_d;
    logic [3:0]       buf_q [MAX_DIGITS];

    logic [3:0]       rx_digit;
    logic             is_digit, is_term, is_bksp;
    logic             push;
    logic [3:0]       cur_digit;
    logic [WIDTH:0]   mac;

    ascii_digit_classify u_classify (
        .char_i     (rx_data),
        .digit_o    (rx_digit),
        .is_digit_o (is_digit),
        .is_term_o  (is_term),
        .is_bksp_o  (is_bksp)
    );

    // acc*10 + d evaluated 4 bits wider than the result; MSB of return flags saturation.
    function automatic logic [WIDTH:0] mac_sat(input logic [WIDTH-1:0] acc,
                                               input logic [3:0]       d);
        logic [WIDTH+3:0] wide;
        wide = (WIDTH+4)'(acc) * (WIDTH+4)'(10) + (WIDTH+4)'(d);
        if (wide[WIDTH+3:WIDTH] != 4'd0)
            return {1'b1, {WIDTH{1'b1}}};
        return {1'b0, wide[WIDTH-1:0]};
    endfunction

    assign cur_digit = buf_q[idx_q];
    assign mac       = mac_sat(acc_q, cur_digit);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        vld_d    = vld_q;
        err_d    = 1'b0;
        push     = 1'b0;
        rx_ready = (state_q == COLLECT);

        case (state_q)
            COLLECT: begin
                if (rx_valid) begin
                    if (is_digit) begin
                        if (cnt_q < CW'(MAX_DIGITS)) begin
                            push  = 1'b1;
                            cnt_d = cnt_q + CW'(1);
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (is_term) begin
                        if (cnt_q != '0) begin
                            state_d = CONVERT;
                            idx_d   = '0;
                            acc_d   = '0;
                            ovf_d   = 1'b0;
                        end
                    end else if (is_bksp && BKSP_EN) begin
                        if (cnt_q != '0)
                            cnt_d = cnt_q - CW'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            CONVERT: begin
                // Sticky saturation: once the flag is set the accumulator is pinned at all-ones.
                acc_d = (ovf_q || mac[WIDTH]) ? {WIDTH{1'b1}} : mac[WIDTH-1:0];
                ovf_d = ovf_q | mac[WIDTH];
                idx_d = idx_q + CW'(1);
                if (idx_q == cnt_q - CW'(1)) begin
                    state_d = PRESENT;
                    vld_d   = 1'b1;
                end
            end

            PRESENT: begin
                if (num_ready) begin
                    state_d = COLLECT;
                    vld_d   = 1'b0;
                    cnt_d   = '0;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                end
            end

            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

    // Digit storage is pure data; slots above digit_count are never read.
    always_ff @(posedge clk) begin
        if (push)
            buf_q[cnt_q] <= rx_digit;
    end

    assign num_value    = acc_q;
    assign num_valid    = vld_q;
    assign num_overflow = ovf_q;
    assign err_pulse    = err_q;
    assign digit_count  = cnt_q;

endmodule

// File: tb/tb_decimal_entry_ctrl.sv
// Directed bench for decimal_entry_ctrl (WIDTH=16, MAX_DIGITS=5).
module tb_decimal_entry_ctrl;

    localparam logic [7:0] CR  = 8'h0D;
    localparam logic [7:0] LF  = 8'h0A;
    localparam logic [7:0] BS  = 8'h08;
    localparam logic [7:0] DEL = 8'h7F;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [15:0] num_value;
    logic        num_valid;
    logic        num_ready;
    logic        num_overflow;
    logic        err_pulse;
    logic [2:0]  digit_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    decimal_entry_ctrl #(.WIDTH(16), .MAX_DIGITS(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .num_value    (num_value),
        .num_valid    (num_valid),
        .num_ready    (num_ready),
        .num_overflow (num_overflow),
        .err_pulse    (err_pulse),
        .digit_count  (digit_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (num_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk(tag, num_valid, 1);
    endtask

    task automatic ack();
        num_ready = 1'b1;
        tick();
        num_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        num_ready = 1'b0;
        tick();
        tick();
        chk("rst_rx_ready", rx_ready, 1);
        chk("rst_num_valid", num_valid, 0);
        chk("rst_num_value", num_value, 0);
        chk("rst_ovf", num_overflow, 0);
        chk("rst_err", err_pulse, 0);
        chk("rst_count", digit_count, 0);
        reset = 1'b0;
        tick();

        // "123" CR with num_ready tied high: exact latency and one-cycle result
        num_ready = 1'b1;
        send("1");
        chk("t1_count1", digit_count, 1);
        send("2");
        send("3");
        chk("t1_count3", digit_count, 3);
        send(CR);
        chk("t1_busy_ready", rx_ready, 0);
        chk("t1_T1_valid", num_valid, 0);
        tick();
        tick();
        chk("t1_T3_valid", num_valid, 0);
        tick();
        chk("t1_T4_valid", num_valid, 1);
        chk("t1_value", num_value, 123);
        chk("t1_ovf", num_overflow, 0);
        chk("t1_T4_ready", rx_ready, 0);
        tick();
        chk("t1_T5_valid", num_valid, 0);
        chk("t1_T5_ready", rx_ready, 1);
        chk("t1_T5_count", digit_count, 0);
        num_ready = 1'b0;

        // "65536" LF saturates
        send("6"); send("5"); send("5"); send("3"); send("6"); send(LF);
        wait_valid("t2_valid");
        chk("t2_value", num_value, 65535);
        chk("t2_ovf", num_overflow, 1);
        ack();
        chk("t2_after_valid", num_valid, 0);
        chk("t2_after_ovf", num_overflow, 0);

        // "65535" fits exactly
        send("6"); send("5"); send("5"); send("3"); send("5"); send(CR);
        wait_valid("t3_valid");
        chk("t3_value", num_value, 65535);
        chk("t3_ovf", num_overflow, 0);
        ack();

        // invalid byte 'A' between digits
        send("4");
        send("2");
        chk("t4_no_err", err_pulse, 0);
        send("A");
        chk("t4_err", err_pulse, 1);
        chk("t4_count", digit_count, 2);
        tick();
        chk("t4_err_one_cycle", err_pulse, 0);
        send(CR);
        wait_valid("t4_valid");
        chk("t4_value", num_value, 42);
        chk("t4_ovf", num_overflow, 0);
        ack();

        // sixth digit is dropped with an error; value built from the first five
        send("1"); send("2"); send("3"); send("4"); send("5");
        chk("t5_err_pre", err_pulse, 0);
        send("6");
        chk("t5_err", err_pulse, 1);
        chk("t5_count", digit_count, 5);
        send(CR);
        wait_valid("t5_valid");
        chk("t5_value", num_value, 12345);
        chk("t5_ovf", num_overflow, 0);
        ack();

        // terminator on an empty buffer is ignored
        send(CR);
        chk("t6_err", err_pulse, 0);
        chk("t6_ready", rx_ready, 1);
        chk("t6_count", digit_count, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t6_no_valid", num_valid, 0);
        end

        // consumer stalls 10 cycles; pending byte must not be consumed
        send("9"); send("9"); send(CR);
        wait_valid("t7_valid");
        rx_data  = "5";
        rx_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t7_hold_valid", num_valid, 1);
            chk("t7_hold_value", num_value, 99);
            chk("t7_hold_ready", rx_ready, 0);
            chk("t7_hold_count", digit_count, 2);
        end
        rx_valid = 1'b0;
        ack();
        chk("t7_after_valid", num_valid, 0);
        chk("t7_after_ready", rx_ready, 1);
        tick();
        chk("t7_not_consumed", digit_count, 0);

        // reset while presenting a saturated value
        send("7"); send("0"); send("0"); send("0"); send("0"); send(CR);
        wait_valid("t8_valid");
        chk("t8_ovf_pre", num_overflow, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t8_valid", num_valid, 0);
        chk("t8_value", num_value, 0);
        chk("t8_ovf", num_overflow, 0);
        chk("t8_count", digit_count, 0);
        chk("t8_ready", rx_ready, 1);
        chk("t8_err", err_pulse, 0);
        tick();
        chk("t8_no_emit", num_valid, 0);

`ifdef DEC_ENTRY_BACKSPACE_EN
        send("1"); send("2"); send(BS);
        chk("t9_bs_count", digit_count, 1);
        chk("t9_bs_err", err_pulse, 0);
        send("5"); send(CR);
        wait_valid("t9_valid");
        chk("t9_value", num_value, 15);
        ack();
        send(DEL);
        chk("t9_empty_err", err_pulse, 0);
        chk("t9_empty_count", digit_count, 0);
`else
        send("3");
        send(BS);
        chk("t9_bs_err", err_pulse, 1);
        chk("t9_bs_count", digit_count, 1);
        send(DEL);
        chk("t9_del_err", err_pulse, 1);
        tick();
        chk("t9_err_clear", err_pulse, 0);
        send(CR);
        wait_valid("t9_valid");
        chk("t9_value", num_value, 3);
        ack();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
